// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width and the divider state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, try to subtract the divisor.
module div_step
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // The shifted remainder needs one extra bit; after a successful subtract it fits in WIDTH again.
    always_comb begin
        shifted  = {rem, q_msb};
        fits     = (shifted >= {1'b0, divisor});
        q_bit    = fits;
        rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, results on a done pulse.
module div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q_msb    (q_reg[WIDTH-1]),
        .divisor  (div_mag),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    // On a zero divisor the quotient register carries the raw dividend straight to FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            rem         <= '0;
            q_reg       <= '0;
            div_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
                        count    <= CNT_W'(WIDTH - 1);
                        rem      <= '0;
                        div_mag  <= dvs_mag;
                        zero_div <= (divisor == '0);
                        q_reg    <= (divisor == '0) ? dividend : dvd_mag;
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    q_reg <= {q_reg[WIDTH-2:0], q_bit};
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    if (zero_div) begin
                        quotient  <= '1;
                        remainder <= q_reg;
                    end else begin
                        quotient  <= neg_q ? -q_reg : q_reg;
                        remainder <= neg_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands vs. an arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int pass_count;
    int check_count;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; zero divisor gives all ones / dividend.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                                     output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Drives one start pulse; returns at the falling edge after the accepting rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            checkOutput("busy_done_excl", 32'(busy & done), 32'd0);
            if (done) break;
        end
    endtask

    task automatic checkResults(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        refModel(a, b, s, eq, er, ez);
        checkOutput("quotient", quotient, eq);
        checkOutput("remainder", remainder, er);
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(ez));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic finishPulse();
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    // Full operation ending in the done cycle.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s);
        int lat;
        applyStimulus(a, b, s);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
        checkResults(a, b, s);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        pass_count  = 0;
        check_count = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        is_signed   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_quotient", quotient, 32'd0);
        checkOutput("rst_remainder", remainder, 32'd0);
        checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp(32'd100, 32'd7, 1'b0);
        checkOutput("q_100_7", quotient, 32'd14);
        checkOutput("r_100_7", remainder, 32'd2);
        finishPulse();
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        checkOutput("q_m7_2", quotient, 32'hFFFF_FFFD);
        checkOutput("r_m7_2", remainder, 32'hFFFF_FFFF);
        finishPulse();
        runOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        finishPulse();
        runOp(32'd5, 32'd0, 1'b0);
        checkOutput("dbz_5_0", 32'(div_by_zero), 32'd1);
        finishPulse();
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        checkOutput("q_ovf", quotient, 32'h8000_0000);
        finishPulse();
        runOp(32'hFFFF_FFFF, 32'd1, 1'b0);
        finishPulse();
        runOp(32'h8000_0000, 32'd0, 1'b1);
        finishPulse();

        // A start while busy must not disturb the running divide.
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(32'd9, 32'd3, 1'b0);
        waitDone(lat);
        checkOutput("latency_ignored_start", 32'(lat), 32'd28);
        checkResults(32'd100, 32'd7, 1'b0);

        // Back-to-back: start issued during the done cycle.
        applyStimulus(32'd9, 32'd3, 1'b0);
        checkOutput("b2b_done_low", 32'(done), 32'd0);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput("latency_b2b", 32'(lat), 32'd33);
        checkResults(32'd9, 32'd3, 1'b0);
        finishPulse();

        // Reset in the middle of an operation.
        applyStimulus(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_quotient", quotient, 32'd0);
        checkOutput("midrst_remainder", remainder, 32'd0);
        checkOutput("midrst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_rst", 32'(done), 32'd0);
        end
        runOp(32'd1000, 32'd3, 1'b0);
        checkOutput("q_1000_3", quotient, 32'd333);
        checkOutput("r_1000_3", remainder, 32'd1);
        finishPulse();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'(($urandom & 1));
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = -32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && $urandom_range(0, 1) == 1) rb = 32'd1;
            runOp(ra, rb, rs);
            finishPulse();
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
